// File: rtl/pattern_comparator_if.sv
// Bus between the sniffer controller and the byte-serial pattern comparator.
// The master programs the pattern and streams bytes; the slave reports status.
interface pattern_comparator_if #(
    parameter int PATTERN_BYTES = 4,
    parameter int OFFSET_W      = 16
);
    logic                       load_pattern;
    logic [8*PATTERN_BYTES-1:0] pattern_in;
    logic [PATTERN_BYTES-1:0]   mask_in;
    logic                       data_valid;
    logic [7:0]                 data_in;
    logic                       clear;
    logic                       update_done;
    logic                       match;
    logic [OFFSET_W-1:0]        match_offset;
    logic                       armed;

    modport master (
        output load_pattern,
        output pattern_in,
        output mask_in,
        output data_valid,
        output data_in,
        output clear,
        input  update_done,
        input  match,
        input  match_offset,
        input  armed
    );

    modport slave (
        input  load_pattern,
        input  pattern_in,
        input  mask_in,
        input  data_valid,
        input  data_in,
        input  clear,
        output update_done,
        output match,
        output match_offset,
        output armed
    );
endinterface

// File: rtl/pattern_comparator.sv
// Sliding-window byte matcher: compares the last PATTERN_BYTES stream bytes
// against a maskable pattern and keeps a sticky flag plus first-hit offset.
module pattern_comparator #(
    parameter int PATTERN_BYTES = 4,
    parameter int OFFSET_W      = 16
) (
    input logic                  clk,
    input logic                  n_rst,
    pattern_comparator_if.slave  bus
);
    localparam int WIN_W  = 8 * PATTERN_BYTES;
    localparam int FILL_W = $clog2(PATTERN_BYTES + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_BYTES);

    typedef enum logic [1:0] {
        UNLOADED,
        ARMED,
        MATCHED
    } state_t;

    state_t                  state_reg;
    logic [WIN_W-1:0]        pattern_reg;
    logic [PATTERN_BYTES-1:0] mask_reg;
    logic [WIN_W-1:0]        window_reg;
    logic [FILL_W-1:0]       fill_reg;
    logic [OFFSET_W-1:0]     offset_reg;
    logic                    match_reg;
    logic [OFFSET_W-1:0]     match_offset_reg;
    logic                    update_done_reg;
    logic                    armed_reg;

    // A clear in the same cycle as a byte restarts the window before the byte lands.
    logic [WIN_W-1:0]        window_base;
    logic [WIN_W-1:0]        window_next;
    logic [FILL_W-1:0]       fill_base;
    logic [FILL_W-1:0]       fill_next;
    logic [OFFSET_W-1:0]     byte_offset;
    logic [OFFSET_W-1:0]     offset_next;
    logic [PATTERN_BYTES-1:0] byte_hit;
    logic                    hit;

    assign window_base = bus.clear ? '0 : window_reg;
    assign fill_base   = bus.clear ? '0 : fill_reg;
    assign byte_offset = bus.clear ? '0 : offset_reg;

    assign window_next = (window_base << 8) | WIN_W'(bus.data_in);
    assign fill_next   = (fill_base == FILL_FULL) ? fill_base : fill_base + FILL_W'(1);
    assign offset_next = (byte_offset == '1) ? byte_offset : byte_offset + OFFSET_W'(1);

    generate
        for (genvar gi = 0; gi < PATTERN_BYTES; gi++) begin : g_cmp
            assign byte_hit[gi] = ~mask_reg[gi] |
                                  (window_next[8*gi +: 8] == pattern_reg[8*gi +: 8]);
        end
    endgenerate

    assign hit = (fill_next == FILL_FULL) && (&byte_hit);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg        <= UNLOADED;
            pattern_reg      <= '0;
            mask_reg         <= '0;
            window_reg       <= '0;
            fill_reg         <= '0;
            offset_reg       <= '0;
            match_reg        <= 1'b0;
            match_offset_reg <= '0;
            update_done_reg  <= 1'b0;
            armed_reg        <= 1'b0;
        end else if (bus.load_pattern) begin
            // Re-programming wins over clear and swallows any byte in this cycle.
            state_reg        <= ARMED;
            pattern_reg      <= bus.pattern_in;
            mask_reg         <= bus.mask_in;
            window_reg       <= '0;
            fill_reg         <= '0;
            offset_reg       <= '0;
            match_reg        <= 1'b0;
            match_offset_reg <= '0;
            update_done_reg  <= 1'b1;
            armed_reg        <= 1'b1;
        end else begin
            update_done_reg <= 1'b0;
            case (state_reg)
                UNLOADED: begin
                    if (bus.clear) begin
                        window_reg <= '0;
                        fill_reg   <= '0;
                        offset_reg <= '0;
                    end
                end
                ARMED, MATCHED: begin
                    if (bus.data_valid) begin
                        window_reg <= window_next;
                        fill_reg   <= fill_next;
                        offset_reg <= offset_next;
                        // First hit since clear/load wins; later hits only keep the flag up.
                        if (hit && (state_reg == ARMED || bus.clear)) begin
                            state_reg        <= MATCHED;
                            match_reg        <= 1'b1;
                            match_offset_reg <= byte_offset;
                        end else if (bus.clear) begin
                            state_reg        <= ARMED;
                            match_reg        <= 1'b0;
                            match_offset_reg <= '0;
                        end
                    end else if (bus.clear) begin
                        state_reg        <= ARMED;
                        window_reg       <= '0;
                        fill_reg         <= '0;
                        offset_reg       <= '0;
                        match_reg        <= 1'b0;
                        match_offset_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= UNLOADED;
                end
            endcase
        end
    end

    assign bus.update_done  = update_done_reg;
    assign bus.match        = match_reg;
    assign bus.match_offset = match_offset_reg;
    assign bus.armed        = armed_reg;

endmodule

// File: doc/pattern_comparator.md
Name: pattern_comparator

Overview:
- Byte-serial pattern matcher that sits directly upstream of the sniffer controller.
- Consumes the packet byte stream read out of the input FIFO and compares a sliding window of the last PATTERN_BYTES bytes against a programmed, maskable pattern.
- Raises a sticky match flag and records the byte offset where the match completed.
- The controller samples the match flag after the packet drains and drops it with clear.

Parameters:
PATTERN_BYTES, 4, window/pattern length in bytes (range 1..8)
OFFSET_W, 16, width of byte offset counter and match_offset

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous active-low
load_pattern  in  1  one-cycle strobe: latch pattern_in/mask_in
pattern_in  in  8*PATTERN_BYTES  pattern; bits [8*PATTERN_BYTES-1 -: 8] = first byte on wire
mask_in  in  PATTERN_BYTES  per-byte compare enable (1 = compare, 0 = don't care); bit PATTERN_BYTES-1 = first byte
data_valid  in  1  data_in valid this cycle (FIFO read data)
data_in  in  8  packet byte
clear  in  1  drop match flag, reset window and offset (packet boundary)
update_done  out  1  one-cycle pulse, pattern latched
match  out  1  sticky match flag
match_offset  out  OFFSET_W  offset of the last byte of the first match in the current packet
armed  out  1  a pattern has been loaded

Behaviour:
- Reset (n_rst low at a clk edge):
  - State UNLOADED.
  - All outputs 0; window, fill count, offset, pattern and mask all 0.
  - Reset mid-packet discards everything, including the loaded pattern.
- States:
  - UNLOADED -> ARMED on load_pattern.
  - ARMED -> MATCHED on a window hit.
  - MATCHED -> ARMED on clear.
  - Any state -> ARMED on load_pattern (re-program).
- UNLOADED: data_valid is ignored and match stays 0.
- load_pattern:
  - Latches pattern/mask and clears window, fill count, offset, match and match_offset.
  - update_done = 1 in the following cycle only. armed = 1 from the following cycle.
  - A data byte presented in the same cycle is discarded.
- Byte acceptance (ARMED or MATCHED, data_valid=1):
  - Window shifts left by one byte; data_in enters the LSB byte.
  - fill count increments, saturating at PATTERN_BYTES.
  - Byte offset increments, saturating at 2^OFFSET_W-1.
  - The first byte after clear/load has offset 0.
- Hit condition, evaluated on the post-shift window:
  - fill == PATTERN_BYTES, and
  - every masked-in byte equals the corresponding pattern byte.
- Hit timing:
  - match rises in the cycle after the completing byte is accepted (1-cycle latency).
  - match_offset loads that byte's offset in the same cycle.
- In MATCHED, further hits do not update match_offset (first match wins). Bytes are still shifted and counted.
- All-zero mask: a hit occurs once fill reaches PATTERN_BYTES, i.e. the match_offset of the first hit is PATTERN_BYTES-1.
- Packets shorter than PATTERN_BYTES never match.
- clear:
  - match=0, match_offset=0, window/fill/offset cleared, state ARMED (if not UNLOADED).
  - clear and data_valid in the same cycle: clear applies first, then the byte is accepted as offset 0 of the new window.
  - clear in the same cycle as a completing byte: no match is reported for the old window.
  - clear while UNLOADED has no effect beyond resetting the counters.
- load_pattern and clear in the same cycle: load_pattern wins (it is a superset).
- Overlapping patterns are detected. With pattern AA AA, the stream AA AA AA hits at offsets 1 and 2; offset 1 is reported.
- No backpressure: one byte per cycle maximum, every valid byte is consumed.

Test Plan:
1. Reset, then load_pattern with pattern=DEADBEEF, mask=F -> update_done pulses exactly 1 cycle later; armed=1; match=0.
2. Armed with DEADBEEF; stream 00 11 DE AD BE EF 22 -> match=1 the cycle after EF is accepted; match_offset=5; match stays 1 through byte 22 and idle cycles.
3. Pattern=DE00BE00, mask=1010b; stream DE 55 BE 77 -> match with match_offset=3. Stream DE 55 BF 77 after clear -> match stays 0.
4. Matched state; pulse clear together with data_valid/data_in=DE; then send AD BE EF -> match drops the next cycle, re-asserts with match_offset=3.
5. Stream DE AD BE with gaps in data_valid (valid every other cycle), then EF with clear asserted in the same cycle -> no match; window holds only EF at fill=1.
6. Assert n_rst low mid-stream after 2 pattern bytes, then release and send the remaining bytes -> match=0, armed=0, bytes ignored until load_pattern; mask=0 after reload gives match_offset=3 on the 4th byte.
